// File: rtl/sdram_port_arbiter_pkg.sv
// Shared types and constants for the SDRAM port arbiter.
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam int MAX_REQ     = 8;
  localparam int BURST_BEATS = 16;

  // Width of a requester index; a single bit is kept even for tiny NUM_REQ.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first set request at or
// after i_ptr wins, wrapping from N-1 back to 0.
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [PTR_W-1:0] o_grant,
  output logic             o_any
);

  // Scan N positions starting at the pointer; the first hit is kept.
  always_comb begin
    int   idx;
    logic hit;
    o_grant = '0;
    o_any   = 1'b0;
    idx     = 0;
    hit     = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(i_ptr) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      hit = 1'b0;
      for (int j = 0; j < N; j++) begin
        if (j == idx) begin
          hit = i_req[j];
        end
      end
      if (!o_any && hit) begin
        o_any   = 1'b1;
        o_grant = idx[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller port between NUM_REQ masters, one transaction
// outstanding at a time. Requester 0 may be given fixed top priority; the
// rest share round-robin. Responses are steered only to the owner.
//
//   state | meaning
//   IDLE  | no transaction; arbitrate and latch the winner's request
//   ISSUE | sdram_req held with latched fields until the controller acks
//   BUSY  | accepted; forward read beats / completion to the owner
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 26,
  parameter int HIPRI_EN = 1
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [NUM_REQ-1:0]        i_m_req,
  input  logic [NUM_REQ*ADDR_W-1:0] i_m_addr,
  input  logic [NUM_REQ-1:0]        i_m_write,
  input  logic [NUM_REQ*32-1:0]     i_m_wdata,
  input  logic [NUM_REQ*4-1:0]      i_m_wmask,
  output logic [NUM_REQ-1:0]        o_m_ack,
  output logic [NUM_REQ-1:0]        o_m_rdvalid,
  output logic [NUM_REQ-1:0]        o_m_complete,
  output logic [31:0]               o_m_rdata,
  output logic                      o_sdram_req,
  output logic [ADDR_W-1:0]         o_sdram_addr,
  output logic                      o_sdram_write,
  output logic [31:0]               o_sdram_wdata,
  output logic [3:0]                o_sdram_wmask,
  input  logic                      i_sdram_ack,
  input  logic [31:0]               i_sdram_rdata,
  input  logic                      i_sdram_rdvalid,
  input  logic                      i_sdram_complete
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [PTR_W-1:0]    r_owner;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic                r_sdram_req;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [31:0]         r_wdata;
  logic [3:0]          r_wmask;

  logic [NUM_REQ-1:0]  w_rr_req;
  logic [PTR_W-1:0]    w_rr_grant;
  logic                w_rr_any;
  logic                w_hipri;
  logic                w_any_req;
  logic [PTR_W-1:0]    w_grant;
  logic [PTR_W:0]      w_ptr_inc;
  logic [PTR_W-1:0]    w_rr_nxt;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic                w_sel_write;
  logic [31:0]         w_sel_wdata;
  logic [3:0]          w_sel_wmask;

  // With top priority enabled requester 0 never takes part in the rotation.
  always_comb begin
    w_rr_req = i_m_req;
    if (HIPRI_EN != 0) begin
      w_rr_req[0] = 1'b0;
    end
  end

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req   (w_rr_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_rr_grant),
    .o_any   (w_rr_any)
  );

  assign w_hipri   = (HIPRI_EN != 0) && i_m_req[0];
  assign w_any_req = w_hipri || w_rr_any;
  assign w_grant   = w_hipri ? '0 : w_rr_grant;

  // Next round-robin pointer: one past the winner, wrapping, never landing on 0 in priority mode.
  always_comb begin
    w_ptr_inc = {1'b0, w_rr_grant} + 1'b1;
    if (int'(w_ptr_inc) >= NUM_REQ) begin
      w_rr_nxt = '0;
    end else begin
      w_rr_nxt = w_ptr_inc[PTR_W-1:0];
    end
    if ((HIPRI_EN != 0) && (w_rr_nxt == '0)) begin
      w_rr_nxt[0] = 1'b1;
    end
  end

  // Select the winning master's request fields.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_write = 1'b0;
    w_sel_wdata = '0;
    w_sel_wmask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant == PTR_W'(i)) begin
        w_sel_addr  = i_m_addr[i*ADDR_W +: ADDR_W];
        w_sel_write = i_m_write[i];
        w_sel_wdata = i_m_wdata[i*32 +: 32];
        w_sel_wmask = i_m_wmask[i*4 +: 4];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and owner-steered responses; nothing reaches a master outside ISSUE/BUSY.
  always_comb begin
    w_state_nxt  = r_state;
    o_m_ack      = '0;
    o_m_rdvalid  = '0;
    o_m_complete = '0;
    case (r_state)
      IDLE:    if (w_any_req) w_state_nxt = ISSUE;
      ISSUE:   if (i_sdram_ack) w_state_nxt = i_sdram_complete ? IDLE : BUSY;
      BUSY:    if (i_sdram_complete) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_owner == PTR_W'(i)) begin
        o_m_ack[i]      = (r_state == ISSUE) && i_sdram_ack;
        o_m_rdvalid[i]  = (r_state == BUSY) && i_sdram_rdvalid;
        o_m_complete[i] = (((r_state == ISSUE) && i_sdram_ack) || (r_state == BUSY))
                          && i_sdram_complete;
      end
    end
  end

  // Latch the winner in IDLE and hold everything stable until the controller acks.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_sdram_req <= 1'b0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_wmask     <= '0;
    end else if ((r_state == IDLE) && w_any_req) begin
      r_owner     <= w_grant;
      r_addr      <= w_sel_addr;
      r_write     <= w_sel_write;
      r_wdata     <= w_sel_wdata;
      r_wmask     <= w_sel_wmask;
      r_sdram_req <= 1'b1;
      if (!w_hipri) begin
        r_rr_ptr <= w_rr_nxt;
      end
    end else if ((r_state == ISSUE) && i_sdram_ack) begin
      r_sdram_req <= 1'b0;
    end
  end

  assign o_sdram_req   = r_sdram_req;
  assign o_sdram_addr  = r_addr;
  assign o_sdram_write = r_write;
  assign o_sdram_wdata = r_wdata;
  assign o_sdram_wmask = r_wmask;
  assign o_m_rdata     = i_sdram_rdata;

  // Controller protocol errors are ignored by the logic but flagged in simulation.
  a_ack_in_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (r_state == IDLE) |-> !i_sdram_ack);
  a_resp_in_idle: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (r_state == IDLE) |-> !(i_sdram_rdvalid || i_sdram_complete));
  a_resp_in_issue: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    (r_state == ISSUE) |-> (!i_sdram_rdvalid && (!i_sdram_complete || i_sdram_ack)));

endmodule
